// File: rtl/tick_gen_pkg.sv
// Shared constants for the tick generator: channel limits, default game rates
// and the helper that pulls one channel's reset divisor out of DIV_INIT.
package tick_gen_pkg;

  localparam int TICK_MAX_CH = 16;
  localparam int TICK_MAX_W  = 64;
  localparam int TICK_INIT_W = TICK_MAX_CH * TICK_MAX_W;

  localparam int FALL_DIV   = 4_000_000;
  localparam int DIGIT_DIV  = 200_000;
  localparam int ONE_HZ_DIV = 50_000_000;
  localparam int PIX_DIV    = 2;

  // Channel ch occupies bits [ch*w +: w] of the packed initial-divisor vector.
  function automatic logic [TICK_MAX_W-1:0] div_slice(
    input logic [TICK_INIT_W-1:0] init,
    input int                     ch,
    input int                     w
  );
    logic [TICK_INIT_W-1:0] shifted;
    logic [TICK_MAX_W-1:0]  mask;
    shifted = init >> (ch * w);
    mask    = (w >= TICK_MAX_W) ? '1 : ((TICK_MAX_W'(1) << w) - TICK_MAX_W'(1));
    return shifted[TICK_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One timebase channel: free-running counter with a shadowed divisor that only
// swaps in at a period boundary, while disabled, or on a global sync.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DIV_INIT_CH = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] shd;
  logic [CNT_W-1:0] last;
  logic             at_last;

  // A zero divisor is treated as one, so the terminal count is never below zero.
  always_comb begin
    last    = (div == '0) ? '0 : div - CNT_W'(1);
    at_last = (cnt == last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      div  <= DIV_INIT_CH;
      shd  <= DIV_INIT_CH;
      pend <= 1'b0;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else if (sync) begin
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
      pend <= 1'b0;
      if (wr) begin
        div <= wr_div;
        shd <= wr_div;
      end else if (pend) begin
        div <= shd;
      end
    end else begin
      if (!en) begin
        tick <= 1'b0;
        if (pend) begin
          div  <= shd;
          cnt  <= '0;
          pend <= 1'b0;
        end
      end else if (at_last) begin
        cnt  <= '0;
        tick <= 1'b1;
        sq   <= ~sq;
        if (pend) begin
          div  <= shd;
          pend <= 1'b0;
        end
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
      // A write on a commit edge lands in the shadow and waits for the next boundary.
      if (wr) begin
        shd  <= wr_div;
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel timebase: NUM_CH independent tick/square-wave channels with a
// shared divisor write port and a global phase-sync strobe.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = 32,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {32'(PIX_DIV), 32'(ONE_HZ_DIV),
                                                 32'(DIGIT_DIV), 32'(FALL_DIV)},
  localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [TICK_INIT_W-1:0] INIT_WIDE = TICK_INIT_W'(DIV_INIT);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;

    // Channel indices beyond NUM_CH-1 match no decoder, so such writes vanish.
    assign wr = cfg_we && (cfg_ch == CH_W'(i));

    tick_channel #(
      .CNT_W      (CNT_W),
      .DIV_INIT_CH(CNT_W'(div_slice(INIT_WIDE, i, CNT_W)))
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (en[i]),
      .sync  (sync),
      .wr    (wr),
      .wr_div(cfg_div),
      .tick  (tick[i]),
      .sq    (sq[i]),
      .pend  (pend[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: table-driven period checks plus hand-written
// sequences for divisor updates, sync, enable gating and mid-period reset.
module tb_tick_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        sync;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic [3:0]  tick;
  logic [3:0]  sq;
  logic [3:0]  pend;

  logic [2:0]  en2;
  logic        sync2;
  logic        cfg_we2;
  logic [1:0]  cfg_ch2;
  logic [7:0]  cfg_div2;
  logic [2:0]  tick2;
  logic [2:0]  sq2;
  logic [2:0]  pend2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tick_gen #(
    .NUM_CH  (4),
    .CNT_W   (32),
    .DIV_INIT({32'd2, 32'd5, 32'd3, 32'd4})
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .cfg_we (cfg_we),
    .cfg_ch (cfg_ch),
    .cfg_div(cfg_div),
    .tick   (tick),
    .sq     (sq),
    .pend   (pend)
  );

  // Three-channel copy so an index past the last channel is representable.
  tick_gen #(
    .NUM_CH  (3),
    .CNT_W   (8),
    .DIV_INIT({8'd3, 8'd3, 8'd3})
  ) dut2 (
    .clk    (clk),
    .rst    (rst),
    .en     (en2),
    .sync   (sync2),
    .cfg_we (cfg_we2),
    .cfg_ch (cfg_ch2),
    .cfg_div(cfg_div2),
    .tick   (tick2),
    .sq     (sq2),
    .pend   (pend2)
  );

  typedef struct {
    logic [3:0] tick;
    logic [3:0] sq;
    logic [3:0] pend;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] div;
    logic        tick;
    logic        sq;
    logic        pend;
  } seq_t;

  vec_t       vec1 [12];
  seq_t       seq3 [8];
  logic [3:0] sync_tick [12];
  logic [15:0] exp_tick0;
  logic [15:0] exp_sq0;
  logic [15:0] exp_pend0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] e, input logic s, input logic we,
                               input logic [1:0] ch, input logic [31:0] d);
    en      = e;
    sync    = s;
    cfg_we  = we;
    cfg_ch  = ch;
    cfg_div = d;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst     = 1'b1;
    en      = 4'hF;
    sync    = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = 2'd0;
    cfg_div = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec1[0]  = '{4'b0000, 4'b0000, 4'b0000};
    vec1[1]  = '{4'b1000, 4'b1000, 4'b0000};
    vec1[2]  = '{4'b0010, 4'b1010, 4'b0000};
    vec1[3]  = '{4'b1001, 4'b0011, 4'b0000};
    vec1[4]  = '{4'b0100, 4'b0111, 4'b0000};
    vec1[5]  = '{4'b1010, 4'b1101, 4'b0000};
    vec1[6]  = '{4'b0000, 4'b1101, 4'b0000};
    vec1[7]  = '{4'b1001, 4'b0100, 4'b0000};
    vec1[8]  = '{4'b0010, 4'b0110, 4'b0000};
    vec1[9]  = '{4'b1100, 4'b1010, 4'b0000};
    vec1[10] = '{4'b0000, 4'b1010, 4'b0000};
    vec1[11] = '{4'b1011, 4'b0001, 4'b0000};

    seq3[0] = '{1'b1, 32'd0, 1'b0, 1'b0, 1'b1};
    seq3[1] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0};
    seq3[2] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
    seq3[3] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0};
    seq3[4] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
    seq3[5] = '{1'b1, 32'd1, 1'b1, 1'b1, 1'b1};
    seq3[6] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
    seq3[7] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0};

    sync_tick = '{4'b0000, 4'b0000, 4'b1010, 4'b0001, 4'b0000, 4'b1110,
                  4'b0000, 4'b0001, 4'b1010, 4'b0000, 4'b0000, 4'b1111};

    exp_tick0 = 16'h1510;
    exp_sq0   = 16'h0CF0;
    exp_pend0 = 16'h00E0;

    en2      = 3'b111;
    sync2    = 1'b0;
    cfg_we2  = 1'b0;
    cfg_ch2  = 2'd0;
    cfg_div2 = 8'd0;

    // Reset state and the four default rates running together.
    doReset();
    checkOutput("reset_tick", 16'(tick), 16'h0);
    checkOutput("reset_sq", 16'(sq), 16'h0);
    checkOutput("reset_pend", 16'(pend), 16'h0);
    checkOutput("reset_small", 16'({tick2, sq2, pend2}), 16'h0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
      checkOutput($sformatf("rates_tick_e%0d", i + 1), 16'(tick), 16'(vec1[i].tick));
      checkOutput($sformatf("rates_sq_e%0d", i + 1), 16'(sq), 16'(vec1[i].sq));
      checkOutput($sformatf("rates_pend_e%0d", i + 1), 16'(pend), 16'(vec1[i].pend));
    end

    // Divisor 4 -> 2 written at edge 5 takes effect only at the edge-8 boundary.
    doReset();
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(4'hF, 1'b0, e == 5, 2'd0, 32'd2);
      checkOutput($sformatf("upd_tick0_e%0d", e), 16'(tick[0]), 16'(exp_tick0[e]));
      checkOutput($sformatf("upd_sq0_e%0d", e), 16'(sq[0]), 16'(exp_sq0[e]));
      checkOutput($sformatf("upd_pend0_e%0d", e), 16'(pend[0]), 16'(exp_pend0[e]));
    end

    // Divisor 0 then 1: continuous ticks with sq alternating.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'hF, 1'b0, seq3[i].we, 2'd0, seq3[i].div);
      checkOutput($sformatf("d01_tick0_e%0d", i + 13), 16'(tick[0]), 16'(seq3[i].tick));
      checkOutput($sformatf("d01_sq0_e%0d", i + 13), 16'(sq[0]), 16'(seq3[i].sq));
      checkOutput($sformatf("d01_pend0_e%0d", i + 13), 16'(pend[0]), 16'(seq3[i].pend));
    end

    // Write while disabled commits on the following edge; then sync realigns.
    doReset();
    applyStimulus(4'h0, 1'b0, 1'b1, 2'd2, 32'd6);
    checkOutput("dis_wr_pend", 16'(pend), 16'b0100);
    applyStimulus(4'h0, 1'b0, 1'b0, 2'd0, 32'd0);
    checkOutput("dis_commit_pend", 16'(pend), 16'b0000);
    repeat (7) applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
    applyStimulus(4'hF, 1'b1, 1'b1, 2'd3, 32'd3);
    checkOutput("sync_tick", 16'(tick), 16'h0);
    checkOutput("sync_sq", 16'(sq), 16'h0);
    checkOutput("sync_pend", 16'(pend), 16'h0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
      checkOutput($sformatf("sync_tick_e%0d", i + 1), 16'(tick), 16'(sync_tick[i]));
    end

    // Channel 0 paused ten cycles with cnt=2: tick held low, sq held high.
    repeat (2) applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'hE, 1'b0, 1'b0, 2'd0, 32'd0);
      checkOutput($sformatf("hold_tick0_%0d", i), 16'(tick[0]), 16'h0);
      checkOutput($sformatf("hold_sq0_%0d", i), 16'(sq[0]), 16'h1);
    end
    cfg_we2 = 1'b1;
    cfg_ch2 = 2'd3;
    applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
    checkOutput("resume_tick0_1", 16'(tick[0]), 16'h0);
    checkOutput("oob_write_pend", 16'(pend2), 16'h0);
    cfg_ch2 = 2'd2;
    applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
    checkOutput("resume_tick0_2", 16'(tick[0]), 16'h1);
    checkOutput("resume_sq0_2", 16'(sq[0]), 16'h0);
    checkOutput("inrange_write_pend", 16'(pend2), 16'b100);
    cfg_we2 = 1'b0;

    // Reset one edge before a terminal: no tick, everything back to defaults.
    applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
    applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
    applyStimulus(4'hF, 1'b0, 1'b1, 2'd1, 32'd9);
    checkOutput("pre_rst_pend", 16'(pend), 16'b0010);
    rst = 1'b1;
    applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
    checkOutput("rst_mid_tick", 16'(tick), 16'h0);
    checkOutput("rst_mid_sq", 16'(sq), 16'h0);
    checkOutput("rst_mid_pend", 16'(pend), 16'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 32'd0);
      checkOutput($sformatf("post_rst_tick_e%0d", i + 1), 16'(tick), 16'(vec1[i].tick));
      checkOutput($sformatf("post_rst_sq_e%0d", i + 1), 16'(sq), 16'(vec1[i].sq));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
